sik_fetch: RTL and testbench

- Instruction-fetch and prefix-merge stage of the two-thread SIK stack pipeline. Sits directly upstream of the decode/ALU stages.
- Alternates fetch between thread 0 and thread 1 and folds each `pre` prefix into the following instruction's immediate.
- Delivers one (thread, pc, instruction, 16-bit immediate) bundle per transfer over a valid/ready handshake.
- Accepts PC redirects and per-thread halt requests from downstream.

---
 rtl/sik_pkg.sv | 36 +++
 rtl/sik_thread_ctx.sv | 47 ++++
 rtl/sik_fetch.sv | 102 ++++++++++
 tb/tb_sik_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sik_pkg.sv
// Shared widths, opcode map and immediate helper for the SIK stack pipeline.
// Latency: none (declarations only).
// Backpressure: none.
package sik_pkg;

  localparam int WORD    = 16;
  localparam int OPCODE  = 4;
  localparam int PRE     = 4;
  localparam int IMMED12 = 12;

  // Major opcodes, carried in inst[15:12]
  localparam logic [OPCODE-1:0] OP_EXT   = 4'h0;
  localparam logic [OPCODE-1:0] OP_GET   = 4'h1;
  localparam logic [OPCODE-1:0] OP_POP   = 4'h2;
  localparam logic [OPCODE-1:0] OP_PUT   = 4'h3;
  localparam logic [OPCODE-1:0] OP_CALL  = 4'h4;
  localparam logic [OPCODE-1:0] OP_JUMPF = 4'h5;
  localparam logic [OPCODE-1:0] OP_JUMP  = 4'h6;
  localparam logic [OPCODE-1:0] OP_JUMPT = 4'h7;
  localparam logic [OPCODE-1:0] OP_PUSH  = 4'h8;
  localparam logic [OPCODE-1:0] OP_PRE   = 4'hF;

  // Extended ops (OP_EXT), selected by immed12
  localparam logic [IMMED12-1:0] EXT_ADD = 12'h000;
  localparam logic [IMMED12-1:0] EXT_SUB = 12'h001;
  localparam logic [IMMED12-1:0] EXT_AND = 12'h002;
  localparam logic [IMMED12-1:0] EXT_OR  = 12'h003;
  localparam logic [IMMED12-1:0] EXT_XOR = 12'h004;
  localparam logic [IMMED12-1:0] EXT_RET = 12'h010;
  localparam logic [IMMED12-1:0] EXT_SYS = 12'h020;

  function automatic logic [WORD-1:0] sext12(input logic [IMMED12-1:0] v);
    return {{(WORD-IMMED12){v[IMMED12-1]}}, v};
  endfunction

endpackage

// File: rtl/sik_thread_ctx.sv
// Per-thread fetch context: pc, pending prefix nibble, prefix-loaded flag, sticky halt.
// Latency: updates take effect on the next clock edge.
// Backpressure: caller only asserts fetch when the output stage can take a word.
module sik_thread_ctx
  import sik_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch,
  input  logic            is_pre,
  input  logic [PRE-1:0]  pre_val,
  input  logic            redirect,
  input  logic [WORD-1:0] redir_pc,
  input  logic            halt_req,
  output logic [WORD-1:0] pc,
  output logic [PRE-1:0]  prefix,
  output logic            loaded,
  output logic            halted
);

  // Redirect wins over a same-cycle fetch and drops any pending prefix; halt is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      prefix <= '0;
      loaded <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (redirect) begin
        pc     <= redir_pc;
        loaded <= 1'b0;
      end else if (fetch) begin
        pc <= pc + 16'd1;
        if (is_pre) begin
          prefix <= pre_val;
          loaded <= 1'b1;
        end else begin
          loaded <= 1'b0;
        end
      end
      if (halt_req) halted <= 1'b1;
    end
  end

endmodule

// File: rtl/sik_fetch.sv
// Two-thread alternating instruction fetch with pre-prefix folding into a 16-bit immediate.
// Latency: 1 cycle from imem read to out_valid.
// Backpressure: out_valid && !out_ready holds the bundle and freezes all fetch state.
module sik_fetch
  import sik_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC0 = 16'h0000,
  parameter logic [WORD-1:0] RESET_PC1 = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_thread,
  output logic [15:0] out_pc,
  output logic [15:0] out_inst,
  output logic [15:0] out_immed,
  input  logic        redir_valid,
  input  logic        redir_thread,
  input  logic [15:0] redir_pc,
  input  logic [1:0]  thread_halt,
  output logic [1:0]  halted,
  output logic        halt
);

  logic [WORD-1:0] pc     [2];
  logic [PRE-1:0]  prefix [2];
  logic [1:0]      loaded;
  logic            tsel;

  logic            sel;
  logic            fetch_en;
  logic            is_pre;
  logic            redir_sel;
  logic            new_bundle;
  logic            squash_out;
  logic [1:0]      fetch_t;
  logic [1:0]      redir_t;
  logic [WORD-1:0] merged;

  // Thread pick, fetch gating and immediate merge for the word on imem_data.
  always_comb begin
    sel        = halted[tsel] ? ~tsel : tsel;
    fetch_en   = !(out_valid && !out_ready) && !(&halted);
    imem_addr  = pc[sel];
    is_pre     = (imem_data[WORD-1 -: OPCODE] == OP_PRE);
    redir_sel  = redir_valid && (redir_thread == sel);
    new_bundle = fetch_en && !is_pre && !redir_sel;
    squash_out = redir_valid && (redir_thread == out_thread);
    fetch_t    = fetch_en ? (2'b01 << sel) : 2'b00;
    redir_t    = redir_valid ? (2'b01 << redir_thread) : 2'b00;
    merged     = loaded[sel] ? {prefix[sel], imem_data[IMMED12-1:0]}
                             : sext12(imem_data[IMMED12-1:0]);
  end

  for (genvar t = 0; t < 2; t++) begin : g_ctx
    sik_thread_ctx #(
      .RESET_PC (t == 0 ? RESET_PC0 : RESET_PC1)
    ) u_ctx (
      .clk      (clk),
      .reset    (reset),
      .fetch    (fetch_t[t]),
      .is_pre   (is_pre),
      .pre_val  (imem_data[PRE-1:0]),
      .redirect (redir_t[t]),
      .redir_pc (redir_pc),
      .halt_req (thread_halt[t]),
      .pc       (pc[t]),
      .prefix   (prefix[t]),
      .loaded   (loaded[t]),
      .halted   (halted[t])
    );
  end

  // Output bundle register, alternation pointer and the combined halt flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tsel       <= 1'b0;
      halt       <= 1'b0;
      out_valid  <= 1'b0;
      out_thread <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
      out_immed  <= '0;
    end else begin
      halt <= &halted;
      if (fetch_en) tsel <= ~sel;
      if (new_bundle) begin
        out_valid  <= 1'b1;
        out_thread <= sel;
        out_pc     <= pc[sel];
        out_inst   <= imem_data;
        out_immed  <= merged;
      end else if (out_valid && (out_ready || squash_out)) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sik_fetch.sv
module tb_sik_fetch;

  localparam logic [15:0] RST0 = 16'h0000;
  localparam logic [15:0] RST1 = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_thread;
  logic [15:0] out_pc;
  logic [15:0] out_inst;
  logic [15:0] out_immed;
  logic        redir_valid;
  logic        redir_thread;
  logic [15:0] redir_pc;
  logic [1:0]  thread_halt;
  logic [1:0]  halted;
  logic        halt;

  logic [15:0] mem [0:255];
  assign imem_data = mem[imem_addr[7:0]];

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: per-thread pc / prefix / loaded / halted, alternation pointer, output slot.
  logic [15:0] mpc  [2];
  logic [3:0]  mpre [2];
  logic        mld  [2];
  logic [1:0]  mh;
  logic        mts;
  logic        mv;
  logic        mhalt;
  logic [48:0] mb;

  logic [48:0] txq [$];

  sik_fetch #(.RESET_PC0(RST0), .RESET_PC1(RST1)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_thread   (out_thread),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_immed    (out_immed),
    .redir_valid  (redir_valid),
    .redir_thread (redir_thread),
    .redir_pc     (redir_pc),
    .thread_halt  (thread_halt),
    .halted       (halted),
    .halt         (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] mk(input logic t, input logic [15:0] p,
                                     input logic [15:0] i, input logic [15:0] m);
    return {t, p, i, m};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mpc[0] = RST0; mpc[1] = RST1;
    mpre[0] = '0;  mpre[1] = '0;
    mld[0] = 1'b0; mld[1] = 1'b0;
    mh = 2'b00; mts = 1'b0; mv = 1'b0; mhalt = 1'b0; mb = '0;
  endtask

  // One clock of the fetch rules: pick a thread, consume its word, apply redirect/halt.
  task automatic model_step();
    logic        s;
    logic        got;
    logic [15:0] w;
    logic [48:0] nb;
    got = 1'b0;
    nb  = '0;
    s   = mh[mts] ? ~mts : mts;
    w   = mem[mpc[s][7:0]];
    if (!(mv && !out_ready) && mh != 2'b11) begin
      mts = ~s;
      if (!(redir_valid && redir_thread == s)) begin
        if (w[15:12] == 4'hF) begin
          mpre[s] = w[3:0];
          mld[s]  = 1'b1;
        end else begin
          nb  = mk(s, mpc[s], w, mld[s] ? {mpre[s], w[11:0]} : {{4{w[11]}}, w[11:0]});
          got = 1'b1;
          mld[s] = 1'b0;
        end
        mpc[s] = mpc[s] + 16'd1;
      end
    end
    if (redir_valid) begin
      mpc[redir_thread] = redir_pc;
      mld[redir_thread] = 1'b0;
    end
    if (got) begin
      mv = 1'b1;
      mb = nb;
    end else if (mv && (out_ready || (redir_valid && redir_thread == mb[48]))) begin
      mv = 1'b0;
    end
    mhalt = &mh;
    mh    = mh | thread_halt;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // Every-cycle comparison against the reference, plus a log of accepted bundles.
  always @(negedge clk) begin
    if (reset) begin
      chk("out_valid", 64'(out_valid), 64'(mv));
      if (mv) chk("bundle", 64'({out_thread, out_pc, out_inst, out_immed}), 64'(mb));
      chk("imem_addr", 64'(imem_addr), 64'(mpc[mh[mts] ? ~mts : mts]));
      chk("halted", 64'(halted), 64'(mh));
      chk("halt", 64'(halt), 64'(mhalt));
      if (out_valid && out_ready && !(redir_valid && redir_thread == out_thread))
        txq.push_back({out_thread, out_pc, out_inst, out_immed});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_phase();
    reset        = 1'b0;
    out_ready    = 1'b1;
    redir_valid  = 1'b0;
    redir_thread = 1'b0;
    redir_pc     = '0;
    thread_halt  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    txq.delete();
  endtask

  task automatic release_reset();
    step(1);
    reset = 1'b1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"},  64'(out_valid), 64'd0);
    chk({name, "_bundle"}, 64'({out_thread, out_pc, out_inst, out_immed}), 64'd0);
    chk({name, "_halted"}, 64'({halt, halted}), 64'd0);
    chk({name, "_addr"},   64'(imem_addr), 64'(RST0));
  endtask

  initial begin
    reset = 1'b1;
    #2;

    // 1: plain pushes, strict alternation, sign extension
    begin_phase();
    mem[0] = 16'h8005;
    mem[1] = 16'h8FFF;
    #1 chk_zero("rst");
    release_reset();
    step(6);
    chk("p1_b0", 64'(txq[0]), 64'(mk(1'b0, 16'h0000, 16'h8005, 16'h0005)));
    chk("p1_b1", 64'(txq[1]), 64'(mk(1'b1, 16'h0000, 16'h8005, 16'h0005)));
    chk("p1_b2", 64'(txq[2]), 64'(mk(1'b0, 16'h0001, 16'h8FFF, 16'hFFFF)));
    chk("p1_b3", 64'(txq[3]), 64'(mk(1'b1, 16'h0001, 16'h8FFF, 16'hFFFF)));

    // 2: prefix fold, then loaded cleared
    begin_phase();
    mem[0] = 16'hF00A;
    mem[1] = 16'h8123;
    mem[2] = 16'h8001;
    release_reset();
    step(7);
    chk("p2_b0", 64'(txq[0]), 64'(mk(1'b0, 16'h0001, 16'h8123, 16'hA123)));
    chk("p2_b1", 64'(txq[1]), 64'(mk(1'b1, 16'h0001, 16'h8123, 16'hA123)));
    chk("p2_b2", 64'(txq[2]), 64'(mk(1'b0, 16'h0002, 16'h8001, 16'h0001)));
    chk("p2_b3", 64'(txq[3]), 64'(mk(1'b1, 16'h0002, 16'h8001, 16'h0001)));

    // 3: three-cycle stall, then resume alternation with nothing lost
    begin_phase();
    for (int i = 0; i < 16; i++) mem[i] = 16'h8000 | 16'(i);
    release_reset();
    step(3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("p3_hold", 64'({out_valid, out_thread, out_pc, out_inst, out_immed}),
          64'({1'b1, mk(1'b0, 16'h0001, 16'h8001, 16'h0001)}));
      chk("p3_addr", 64'(imem_addr), 64'h1);
    end
    out_ready = 1'b1;
    step(6);
    for (int i = 0; i < 6; i++)
      chk("p3_seq", 64'(txq[i]),
          64'(mk(1'(i % 2), 16'(i / 2), 16'h8000 | 16'(i / 2), 16'(i / 2))));

    // 4: redirect beats fetch and drops prefix; redirect squashes a held bundle
    begin_phase();
    mem[0] = 16'h8001;  mem[1] = 16'hF00B;  mem[2] = 16'h8002;
    mem[3] = 16'h8003;  mem[4] = 16'h8004;
    mem[8'h40] = 16'h8444;
    mem[8'h50] = 16'h8555;
    release_reset();
    step(4);
    redir_valid = 1'b1; redir_thread = 1'b0; redir_pc = 16'h0040;
    step(1);
    redir_valid = 1'b0;
    step(2);
    out_ready = 1'b0;
    step(1);
    chk("p4_held", 64'({out_valid, out_thread, out_pc, out_inst, out_immed}),
        64'({1'b1, mk(1'b0, 16'h0040, 16'h8444, 16'h0444)}));
    redir_valid = 1'b1; redir_thread = 1'b0; redir_pc = 16'h0050;
    step(1);
    redir_valid = 1'b0;
    out_ready   = 1'b1;
    chk("p4_squash", 64'(out_valid), 64'd0);
    step(4);
    chk("p4_b0", 64'(txq[0]), 64'(mk(1'b0, 16'h0000, 16'h8001, 16'h0001)));
    chk("p4_b1", 64'(txq[1]), 64'(mk(1'b1, 16'h0000, 16'h8001, 16'h0001)));
    chk("p4_b2", 64'(txq[2]), 64'(mk(1'b1, 16'h0002, 16'h8002, 16'hB002)));
    chk("p4_b3", 64'(txq[3]), 64'(mk(1'b1, 16'h0003, 16'h8003, 16'h0003)));
    chk("p4_b4", 64'(txq[4]), 64'(mk(1'b0, 16'h0050, 16'h8555, 16'h0555)));

    // 5: halt thread 0, then thread 1
    begin_phase();
    for (int i = 0; i < 16; i++) mem[i] = 16'h8000 | 16'(i);
    release_reset();
    step(4);
    thread_halt = 2'b01;
    step(1);
    thread_halt = 2'b00;
    txq.delete();
    step(3);
    thread_halt = 2'b10;
    step(1);
    thread_halt = 2'b00;
    chk("p5_halted", 64'({halt, halted, out_valid}), 64'({1'b0, 2'b11, 1'b1}));
    step(1);
    chk("p5_halt", 64'({halt, out_valid}), 64'({1'b1, 1'b0}));
    step(2);
    chk("p5_cnt", 64'(txq.size()), 64'd5);
    chk("p5_b0", 64'(txq[0]), 64'(mk(1'b0, 16'h0002, 16'h8002, 16'h0002)));
    chk("p5_b1", 64'(txq[1]), 64'(mk(1'b1, 16'h0002, 16'h8002, 16'h0002)));
    chk("p5_b2", 64'(txq[2]), 64'(mk(1'b1, 16'h0003, 16'h8003, 16'h0003)));
    chk("p5_b3", 64'(txq[3]), 64'(mk(1'b1, 16'h0004, 16'h8004, 16'h0004)));
    chk("p5_b4", 64'(txq[4]), 64'(mk(1'b1, 16'h0005, 16'h8005, 16'h0005)));

    // 6: asynchronous reset during a stall with a thread-1 prefix pending
    begin_phase();
    mem[0] = 16'h8001;
    mem[1] = 16'hF00C;
    mem[2] = 16'h8002;
    release_reset();
    step(5);
    chk("p6_pre", 64'({out_valid, out_thread, out_pc, out_inst, out_immed}),
        64'({1'b1, mk(1'b0, 16'h0002, 16'h8002, 16'hC002)}));
    out_ready = 1'b0;
    step(1);
    #3 reset = 1'b0;
    #1 chk_zero("p6_rst");
    out_ready = 1'b1;
    step(1);
    reset = 1'b1;
    step(1);
    chk("p6_first", 64'({out_valid, out_thread, out_pc, out_inst, out_immed}),
        64'({1'b1, mk(1'b0, 16'h0000, 16'h8001, 16'h0001)}));
    step(1);
    chk("p6_second", 64'({out_valid, out_thread, out_pc, out_inst, out_immed}),
        64'({1'b1, mk(1'b1, 16'h0000, 16'h8001, 16'h0001)}));
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
